// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop synchroniser, falling-edge start detect, mid-bit sampling.
// Define UART_RX_PARITY_EN to add an even-parity bit between data and stop.
module uart_rx #(
  parameter int unsigned CLKS_PER_BIT = 87
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_rx,
  output logic [7:0] o_data,
  output logic       o_valid,
  output logic       o_frame_err,
  output logic       o_parity_err,
  output logic       o_busy
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] MID  = CW'((CLKS_PER_BIT - 1) / 2);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_e;

  logic          sync_q;
  logic          rx_s_q;
  logic          rx_d_q;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    data_q, data_d;
  logic          valid_q, valid_d;
  logic          ferr_q, ferr_d;
  logic          busy_q, busy_d;
`ifdef UART_RX_PARITY_EN
  logic          pbad_q, pbad_d;
  logic          perr_q, perr_d;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync_q <= 1'b1;
      rx_s_q <= 1'b1;
      rx_d_q <= 1'b1;
    end else begin
      sync_q <= i_rx;
      rx_s_q <= sync_q;
      rx_d_q <= rx_s_q;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    idx_d   = idx_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
    pbad_d  = pbad_q;
    perr_d  = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (rx_d_q && !rx_s_q) state_d = START;
      end
      START: begin
        idx_d = '0;
        // Line back high at mid-start means a glitch, not a frame
        if (cnt_q == MID) state_d = rx_s_q ? IDLE : DATA;
      end
      DATA: begin
        if (cnt_q == LAST) begin
          shift_d[idx_q] = rx_s_q;
          idx_d = idx_q + 3'd1;
          if (idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end
      end
      PARITY: begin
`ifdef UART_RX_PARITY_EN
        if (cnt_q == LAST) begin
          pbad_d  = rx_s_q != (^shift_q);
          state_d = STOP;
        end
`else
        state_d = IDLE;
`endif
      end
      STOP: begin
        // Leave at mid-stop so a back-to-back start edge is seen
        if (cnt_q == LAST) begin
          state_d = IDLE;
          if (!rx_s_q) begin
            ferr_d = 1'b1;
`ifdef UART_RX_PARITY_EN
          end else if (pbad_q) begin
            perr_d = 1'b1;
`endif
          end else begin
            valid_d = 1'b1;
            data_d  = shift_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (state_d != state_q) cnt_d = '0;
    if (state_d == IDLE) cnt_d = '0;
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      busy_q  <= busy_d;
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pbad_q <= 1'b0;
      perr_q <= 1'b0;
    end else begin
      pbad_q <= pbad_d;
      perr_q <= perr_d;
    end
  end

  assign o_parity_err = perr_q;
`else
  assign o_parity_err = 1'b0;
`endif

  assign o_data      = data_q;
  assign o_valid     = valid_q;
  assign o_frame_err = ferr_q;
  assign o_busy      = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: directed frame table, hand-written corner sequences,
// and random frames checked against a frame-level reference model.
module tb_uart_rx;

  localparam int CPB = 87;
`ifdef UART_RX_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam int LAT = 2 + 1 + (CPB - 1) / 2 + (9 + PB) * CPB;

  localparam int K_VALID = 0;
  localparam int K_FERR  = 1;
  localparam int K_PERR  = 2;

  typedef struct {
    logic [7:0] d;
    bit         stop;
    bit         bad_par;
    int         gap;
    int         kind;
    logic [7:0] exp_data;
  } vec_t;

  logic       clk;
  logic       rst_n;
  logic       rx;
  logic [7:0] data;
  logic       valid;
  logic       ferr;
  logic       perr;
  logic       busy;

  int         vectors;
  int         miscompares;
  int         cyc;
  logic [7:0] last_good;

  int         obs_kind[$];
  logic [7:0] obs_data[$];
  int         obs_cyc[$];

  vec_t       tbl[$];

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_rx        (rx),
    .o_data      (data),
    .o_valid     (valid),
    .o_frame_err (ferr),
    .o_parity_err(perr),
    .o_busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin : mon
    int n;
    n = int'(valid) + int'(ferr) + int'(perr);
    if (rst_n && n > 0) begin
      vectors++;
      if (n > 1) begin
        miscompares++;
        $display("FAIL pulse_exclusive: got %0d pulses, required 1", n);
      end
      obs_kind.push_back(valid ? K_VALID : (ferr ? K_FERR : K_PERR));
      obs_data.push_back(data);
      obs_cyc.push_back(cyc);
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int got, input int exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, required %0h", name, got, exp);
    end
  endtask

  task automatic drive_bit(input logic b);
    rx = b;
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d, input bit stop, input bit bad_par,
                      output bit busy_mid, output int t_fall);
    t_fall = cyc;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) begin
      drive_bit(d[i]);
      if (i == 3) busy_mid = busy;
    end
`ifdef UART_RX_PARITY_EN
    drive_bit((^d) ^ bad_par);
`else
    if (bad_par) busy_mid = 1'b0;
`endif
    drive_bit(stop);
  endtask

  // Frame-level reference: what a receiver must report for one frame
  task automatic model(input logic [7:0] d, input bit stop, input bit bad_par,
                       output int kind, output logic [7:0] exp_data);
    if (!stop) begin
      kind = K_FERR;
      exp_data = last_good;
    end else if (bad_par && PB == 1) begin
      kind = K_PERR;
      exp_data = last_good;
    end else begin
      kind = K_VALID;
      exp_data = d;
    end
  endtask

  task automatic run_row(input vec_t v);
    bit bm;
    int tf;
    int lat;
    if (v.gap > 0) idle(v.gap);
    send(v.d, v.stop, v.bad_par, bm, tf);
    chk($sformatf("busy_mid_%02h", v.d), int'(bm), 1);
    chk($sformatf("busy_end_%02h", v.d), int'(busy), 0);
    chk($sformatf("events_%02h", v.d), obs_kind.size(), 1);
    if (obs_kind.size() > 0) begin
      chk($sformatf("kind_%02h", v.d), obs_kind[0], v.kind);
      chk($sformatf("data_%02h", v.d), int'(obs_data[0]), int'(v.exp_data));
      lat = obs_cyc[0] - tf;
      vectors++;
      if (lat < LAT - 1 || lat > LAT + 1) begin
        miscompares++;
        $display("FAIL latency_%02h: got %0d, required %0d+-1", v.d, lat, LAT);
      end
    end
    if (v.kind == K_VALID) last_good = v.d;
    obs_kind.delete();
    obs_data.delete();
    obs_cyc.delete();
  endtask

  initial begin
    vec_t v;
    int   k;
    bit   prev_bad;
    vectors = 0;
    miscompares = 0;
    cyc = 0;
    last_good = 8'h00;

    tbl.push_back('{8'hA5, 1'b1, 1'b0, 10, K_VALID, 8'hA5});
    tbl.push_back('{8'h00, 1'b1, 1'b0, 0,  K_VALID, 8'h00});
    tbl.push_back('{8'hFF, 1'b1, 1'b0, 0,  K_VALID, 8'hFF});
    tbl.push_back('{8'h11, 1'b1, 1'b0, 15, K_VALID, 8'h11});
    tbl.push_back('{8'h3C, 1'b0, 1'b0, 0,  K_FERR,  8'h11});
    tbl.push_back('{8'h22, 1'b1, 1'b0, 12, K_VALID, 8'h22});
    tbl.push_back('{8'h5A, 1'b1, 1'b0, 20, K_VALID, 8'h5A});
    tbl.push_back('{8'h07, 1'b1, 1'b1, 9,  K_PERR,  8'h5A});
    tbl.push_back('{8'h07, 1'b1, 1'b0, 9,  K_VALID, 8'h07});

    rst_n = 1'b0;
    rx = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_data", int'(data), 0);
    chk("rst_valid", int'(valid), 0);
    chk("rst_ferr", int'(ferr), 0);
    chk("rst_perr", int'(perr), 0);
    chk("rst_busy", int'(busy), 0);
    rst_n = 1'b1;

    for (int i = 0; i < 5; i++) run_row(tbl[i]);

    // Line stuck low after a bad stop bit must stay silent
    rx = 1'b0;
    repeat (30 * CPB) @(posedge clk);
    #1;
    chk("stuck_low_events", obs_kind.size(), 0);
    chk("stuck_low_busy", int'(busy), 0);
    chk("stuck_low_data", int'(data), 8'h11);
    run_row(tbl[5]);

    // Short low glitch: start rejected at mid-start
    idle(10);
    rx = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("glitch_busy_set", int'(busy), 1);
    repeat (10) @(posedge clk);
    #1;
    rx = 1'b1;
    k = 0;
    while (busy && k < CPB / 2 + 4) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk("glitch_busy_clear", int'(busy), 0);
    repeat (CPB) @(posedge clk);
    #1;
    chk("glitch_events", obs_kind.size(), 0);

    // Reset in the middle of data bit 4
    idle(10);
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(tbl[6].d[i]);
    rx = tbl[6].d[4];
    repeat (CPB / 2) @(posedge clk);
    #1;
    chk("midframe_busy", int'(busy), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_data", int'(data), 0);
    chk("arst_valid", int'(valid), 0);
    chk("arst_ferr", int'(ferr), 0);
    chk("arst_perr", int'(perr), 0);
    chk("arst_busy", int'(busy), 0);
    rx = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    last_good = 8'h00;
    chk("arst_events", obs_kind.size(), 0);
    run_row(tbl[6]);

`ifdef UART_RX_PARITY_EN
    run_row(tbl[7]);
    run_row(tbl[8]);
`endif

    prev_bad = 1'b0;
    for (int i = 0; i < 20; i++) begin
      v.d = 8'($urandom);
      v.stop = ($urandom_range(0, 4) != 0);
      v.bad_par = (PB == 1) && ($urandom_range(0, 3) == 0);
      v.gap = prev_bad ? int'($urandom_range(4, 40)) : int'($urandom_range(0, 40));
      model(v.d, v.stop, v.bad_par, v.kind, v.exp_data);
      run_row(v);
      prev_bad = !v.stop;
    end

    idle(2 * CPB);
    chk("tail_events", obs_kind.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
